// File: rtl/ff_frame_deframer.sv
// Serial-to-byte frame deframer: strips the 24-bit frame ID header and queues
// payload bytes, tagged with last/error, in a FIFO with a valid/ready output.
module ff_frame_deframer #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BYTES  = 1024
) (
  input  logic                        ff_clk,
  input  logic                        reset,
  input  logic                        ff_en,
  input  logic                        ff_data,
  output logic [7:0]                  out_data,
  output logic                        out_last,
  output logic                        out_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [23:0]                 frame_id,
  output logic                        id_valid,
  output logic                        err_short,
  output logic                        err_partial,
  output logic                        err_overflow,
  output logic                        err_long,
  output logic [15:0]                 frame_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(MAX_BYTES + 1) + 1;
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_LAST2 = LW'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [6:0]      sh_q, sh_d;
  logic [1:0]      hdr_cnt_q, hdr_cnt_d;
  logic [15:0]     id_sh_q, id_sh_d;
  logic [23:0]     frame_id_q, frame_id_d;
  logic            id_valid_q, id_valid_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [CW-1:0]   pay_cnt_q, pay_cnt_d;
  logic            err_short_q, err_short_d;
  logic            err_partial_q, err_partial_d;
  logic            err_overflow_q, err_overflow_d;
  logic            err_long_q, err_long_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [9:0]      mem_q [FIFO_DEPTH];

  logic [7:0]      byte_new;
  logic            byte_done;
  logic            free_ge1, free_ge2;
  logic            push, pop;
  logic            push_last, push_err;
  logic [9:0]      ent_d;
  logic [9:0]      head;

  assign byte_new  = {sh_q, ff_data};
  assign byte_done = (bit_cnt_q == 3'd7);
  assign free_ge1  = (level_q != LVL_FULL);
  assign free_ge2  = (level_q <= LVL_LAST2);
  assign ent_d     = {push_err, push_last, pend_q};
  assign head      = mem_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    sh_d           = sh_q;
    hdr_cnt_d      = hdr_cnt_q;
    id_sh_d        = id_sh_q;
    frame_id_d     = frame_id_q;
    id_valid_d     = 1'b0;
    pend_d         = pend_q;
    pend_valid_d   = pend_valid_q;
    pay_cnt_d      = pay_cnt_q;
    err_short_d    = 1'b0;
    err_partial_d  = 1'b0;
    err_overflow_d = 1'b0;
    err_long_d     = 1'b0;
    push           = 1'b0;
    push_last      = 1'b0;
    push_err       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ff_en) begin
          sh_d         = {6'b0, ff_data};
          bit_cnt_d    = 3'd1;
          hdr_cnt_d    = '0;
          pend_valid_d = 1'b0;
          pay_cnt_d    = '0;
          state_d      = S_HDR;
        end
      end
      S_HDR: begin
        if (!ff_en) begin
          err_short_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = S_IDLE;
        end else begin
          sh_d      = byte_new[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            id_sh_d   = {id_sh_q[7:0], byte_new};
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd2) begin
              frame_id_d = {id_sh_q, byte_new};
              id_valid_d = 1'b1;
              state_d    = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!ff_en) begin
          bit_cnt_d    = '0;
          pend_valid_d = 1'b0;
          state_d      = S_IDLE;
          if (!pend_valid_q) begin
            err_short_d = 1'b1;
          end else if (!free_ge1) begin
            // Lone first byte facing a full FIFO: the frame is dropped whole.
            err_overflow_d = 1'b1;
          end else begin
            push          = 1'b1;
            push_last     = 1'b1;
            push_err      = (bit_cnt_q != 3'd0);
            err_partial_d = (bit_cnt_q != 3'd0);
          end
        end else begin
          sh_d      = byte_new[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            if (!pend_valid_q) begin
              pend_d       = byte_new;
              pend_valid_d = 1'b1;
              pay_cnt_d    = CW'(1);
            end else if ((pay_cnt_q != CNT_MAX) && free_ge2) begin
              push      = 1'b1;
              pend_d    = byte_new;
              pay_cnt_d = pay_cnt_q + CW'(1);
            end else begin
              // Overlength or no room: close the frame on the pending byte if a slot exists.
              err_long_d     = (pay_cnt_q == CNT_MAX);
              err_overflow_d = (pay_cnt_q != CNT_MAX);
              push           = free_ge1;
              push_last      = 1'b1;
              push_err       = 1'b1;
              pend_valid_d   = 1'b0;
              bit_cnt_d      = '0;
              state_d        = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        if (!ff_en) begin
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_DROP;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    level_d     = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    if (!push && pop) level_d = level_q - LW'(1);
    frame_cnt_d = frame_cnt_q;
    if (pop && head[8] && !head[9]) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge ff_clk) begin
    if (!reset) begin
      state_q        <= S_DROP;
      bit_cnt_q      <= '0;
      sh_q           <= '0;
      hdr_cnt_q      <= '0;
      id_sh_q        <= '0;
      frame_id_q     <= '0;
      id_valid_q     <= 1'b0;
      pend_q         <= '0;
      pend_valid_q   <= 1'b0;
      pay_cnt_q      <= '0;
      err_short_q    <= 1'b0;
      err_partial_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      err_long_q     <= 1'b0;
      frame_cnt_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      sh_q           <= sh_d;
      hdr_cnt_q      <= hdr_cnt_d;
      id_sh_q        <= id_sh_d;
      frame_id_q     <= frame_id_d;
      id_valid_q     <= id_valid_d;
      pend_q         <= pend_d;
      pend_valid_q   <= pend_valid_d;
      pay_cnt_q      <= pay_cnt_d;
      err_short_q    <= err_short_d;
      err_partial_q  <= err_partial_d;
      err_overflow_q <= err_overflow_d;
      err_long_q     <= err_long_d;
      frame_cnt_q    <= frame_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
    end
  end

  always_ff @(posedge ff_clk) begin
    if (push) mem_q[wr_ptr_q] <= ent_d;
  end

  a_no_push_when_full: assert property (@(posedge ff_clk) disable iff (!reset)
    !(push && (level_q == LVL_FULL)));

  assign out_valid    = (level_q != '0);
  assign out_data     = out_valid ? head[7:0] : '0;
  assign out_last     = out_valid & head[8];
  assign out_err      = out_valid & head[9];
  assign frame_id     = frame_id_q;
  assign id_valid     = id_valid_q;
  assign err_short    = err_short_q;
  assign err_partial  = err_partial_q;
  assign err_overflow = err_overflow_q;
  assign err_long     = err_long_q;
  assign frame_cnt    = frame_cnt_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_ff_frame_deframer.sv
// Bench for ff_frame_deframer: two instances (small FIFO / short MAX_BYTES) share one
// serial stream; popped entries and pulses are scored against a frame-level model.
module tb_ff_frame_deframer;

  localparam int A_DEPTH = 4;
  localparam int A_MAX   = 1024;
  localparam int B_DEPTH = 16;
  localparam int B_MAX   = 4;

  typedef logic [9:0] ent_t;

  logic ff_clk = 1'b0;
  logic reset, ff_en, ff_data, rdy;

  logic [7:0]  a_data, b_data;
  logic        a_last, a_err, a_valid, a_idv, a_es, a_ep, a_eo, a_el;
  logic        b_last, b_err, b_valid, b_idv, b_es, b_ep, b_eo, b_el;
  logic [23:0] a_fid, b_fid;
  logic [15:0] a_fc, b_fc;
  logic [2:0]  a_lvl;
  logic [4:0]  b_lvl;

  int checks = 0;
  int errors = 0;

  always #5 ff_clk = ~ff_clk;

  ff_frame_deframer #(.FIFO_DEPTH(A_DEPTH), .MAX_BYTES(A_MAX)) u_a (
    .ff_clk(ff_clk), .reset(reset), .ff_en(ff_en), .ff_data(ff_data),
    .out_data(a_data), .out_last(a_last), .out_err(a_err), .out_valid(a_valid),
    .out_ready(rdy), .frame_id(a_fid), .id_valid(a_idv), .err_short(a_es),
    .err_partial(a_ep), .err_overflow(a_eo), .err_long(a_el),
    .frame_cnt(a_fc), .fifo_level(a_lvl));

  ff_frame_deframer #(.FIFO_DEPTH(B_DEPTH), .MAX_BYTES(B_MAX)) u_b (
    .ff_clk(ff_clk), .reset(reset), .ff_en(ff_en), .ff_data(ff_data),
    .out_data(b_data), .out_last(b_last), .out_err(b_err), .out_valid(b_valid),
    .out_ready(rdy), .frame_id(b_fid), .id_valid(b_idv), .err_short(b_es),
    .err_partial(b_ep), .err_overflow(b_eo), .err_long(b_el),
    .frame_cnt(b_fc), .fifo_level(b_lvl));

  // Observation side
  ent_t obs_a[$], obs_b[$];
  int n_short[2], n_part[2], n_over[2], n_long[2], n_id[2];
  int s_short[2], s_part[2], s_over[2], s_long[2], s_id[2];

  always @(negedge ff_clk) begin
    if (reset) begin
      if (a_valid && rdy) obs_a.push_back({a_err, a_last, a_data});
      if (b_valid && rdy) obs_b.push_back({b_err, b_last, b_data});
      if (a_idv) n_id[0]++;
      if (b_idv) n_id[1]++;
      if (a_es) n_short[0]++;
      if (b_es) n_short[1]++;
      if (a_ep) n_part[0]++;
      if (b_ep) n_part[1]++;
      if (a_eo) n_over[0]++;
      if (b_eo) n_over[1]++;
      if (a_el) n_long[0]++;
      if (b_el) n_long[1]++;
    end
  end

  // Stimulus: each item is {ff_en, ff_data} for one clock
  logic [1:0] stim[$];

  // Reference model results
  ent_t        m_q[$];
  int          m_short, m_part, m_over, m_long, m_idn, m_good, m_lvl;
  logic [23:0] m_id;
  int          exp_fc[2];

  task automatic tick();
    @(posedge ff_clk);
    #2;
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) stim.push_back({1'b1, v[i]});
  endtask

  task automatic add_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) stim.push_back({1'b1, v[i]});
  endtask

  task automatic add_gap(input int n);
    for (int i = 0; i < n; i++) stim.push_back(2'b00);
  endtask

  task automatic add_header(input logic [23:0] id);
    add_byte(id[23:16]);
    add_byte(id[15:8]);
    add_byte(id[7:0]);
  endtask

  task automatic mpush(input logic [7:0] b, input logic l, input logic e, input bit no_pop);
    m_q.push_back({e, l, b});
    if (no_pop) m_lvl++;
  endtask

  // Frame-level model: split the stream at ff_en=0, then apply the framing rules per
  // frame. Without backpressure every entry drains long before the next push.
  task automatic model_run(input int depth, input int maxb, input bit no_pop);
    logic        bits[$];
    logic [7:0]  by[$];
    logic [7:0]  v;
    int          nb, rem, np, free;
    bit          done;
    m_q.delete();
    m_short = 0; m_part = 0; m_over = 0; m_long = 0; m_idn = 0; m_good = 0; m_lvl = 0;
    m_id = '0;
    for (int i = 0; i < stim.size(); i++) begin
      if (stim[i][1]) begin
        bits.push_back(stim[i][0]);
      end else if (bits.size() > 0) begin
        nb = bits.size() / 8;
        rem = bits.size() % 8;
        by.delete();
        for (int k = 0; k < nb; k++) begin
          v = '0;
          for (int b = 0; b < 8; b++) v = {v[6:0], bits[8*k+b]};
          by.push_back(v);
        end
        if (nb < 3) begin
          m_short++;
        end else begin
          m_idn++;
          m_id = {by[0], by[1], by[2]};
          np = nb - 3;
          done = 0;
          if (np == 0) begin
            m_short++;
          end else begin
            // payload byte p lives at by[p+2]; completing byte j releases byte j-1
            for (int j = 2; j <= np && !done; j++) begin
              free = depth - m_lvl;
              if (j - 1 == maxb) begin
                if (free >= 1) mpush(by[j+1], 1'b1, 1'b1, no_pop);
                m_long++;
                done = 1;
              end else if (free >= 2) begin
                mpush(by[j+1], 1'b0, 1'b0, no_pop);
              end else begin
                if (free == 1) mpush(by[j+1], 1'b1, 1'b1, no_pop);
                m_over++;
                done = 1;
              end
            end
            if (!done) begin
              free = depth - m_lvl;
              if (free == 0) m_over++;
              else if (rem == 0) begin
                mpush(by[np+2], 1'b1, 1'b0, no_pop);
                m_good++;
              end else begin
                mpush(by[np+2], 1'b1, 1'b1, no_pop);
                m_part++;
              end
            end
          end
        end
        bits.delete();
      end
    end
  endtask

  task automatic play_stim();
    obs_a.delete();
    obs_b.delete();
    for (int d = 0; d < 2; d++) begin
      s_short[d] = n_short[d]; s_part[d] = n_part[d]; s_over[d] = n_over[d];
      s_long[d] = n_long[d]; s_id[d] = n_id[d];
    end
    for (int i = 0; i < stim.size(); i++) begin
      ff_en = stim[i][1];
      ff_data = stim[i][0];
      tick();
    end
    ff_en = 1'b0;
    ff_data = 1'b0;
  endtask

  // Drain both FIFOs (bounded) and score both instances against the model.
  task automatic score_run(input string tag, input bit no_pop);
    ent_t        got[$];
    logic [15:0] fc;
    logic [23:0] fid;
    int          cnt;
    cnt = 0;
    repeat (3) tick();
    while ((a_valid || b_valid) && cnt < 200) begin
      tick();
      cnt++;
    end
    checks++;
    if (a_valid || b_valid) begin
      errors++;
      $display("FAIL %s drain: out_valid a=%0b b=%0b, required 0 after 200 cycles", tag, a_valid, b_valid);
    end
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        model_run(A_DEPTH, A_MAX, no_pop);
        got = obs_a; fc = a_fc; fid = a_fid;
      end else begin
        model_run(B_DEPTH, B_MAX, no_pop);
        got = obs_b; fc = b_fc; fid = b_fid;
      end
      exp_fc[d] += m_good;
      checks++;
      if (got.size() != m_q.size()) begin
        errors++;
        $display("FAIL %s/dut%0d entry_count: got %0d, required %0d", tag, d, got.size(), m_q.size());
      end
      for (int i = 0; i < m_q.size() && i < got.size(); i++) begin
        checks++;
        if (got[i] !== m_q[i]) begin
          errors++;
          $display("FAIL %s/dut%0d entry[%0d] {err,last,data}: got %03h, required %03h", tag, d, i, got[i], m_q[i]);
        end
      end
      checks++;
      if ((n_short[d] - s_short[d]) != m_short || (n_part[d] - s_part[d]) != m_part ||
          (n_over[d] - s_over[d]) != m_over || (n_long[d] - s_long[d]) != m_long) begin
        errors++;
        $display("FAIL %s/dut%0d err_pulses short/partial/overflow/long: got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
                 tag, d, n_short[d] - s_short[d], n_part[d] - s_part[d], n_over[d] - s_over[d],
                 n_long[d] - s_long[d], m_short, m_part, m_over, m_long);
      end
      checks++;
      if ((n_id[d] - s_id[d]) != m_idn) begin
        errors++;
        $display("FAIL %s/dut%0d id_valid_pulses: got %0d, required %0d", tag, d, n_id[d] - s_id[d], m_idn);
      end
      if (m_idn > 0) begin
        checks++;
        if (fid !== m_id) begin
          errors++;
          $display("FAIL %s/dut%0d frame_id: got %06h, required %06h", tag, d, fid, m_id);
        end
      end
      checks++;
      if (fc !== 16'(exp_fc[d])) begin
        errors++;
        $display("FAIL %s/dut%0d frame_cnt: got %0d, required %0d", tag, d, fc, 16'(exp_fc[d]));
      end
    end
    obs_a.delete();
    obs_b.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; ff_en = 1'b0; ff_data = 1'b0; rdy = 1'b1;
    repeat (3) tick();
    checks++;
    if ({a_valid, a_last, a_err, a_idv, a_es, a_ep, a_eo, a_el} !== 8'h00 ||
        {b_valid, b_last, b_err, b_idv, b_es, b_ep, b_eo, b_el} !== 8'h00) begin
      errors++;
      $display("FAIL reset flags: got a=%02h b=%02h, required 00",
               {a_valid, a_last, a_err, a_idv, a_es, a_ep, a_eo, a_el},
               {b_valid, b_last, b_err, b_idv, b_es, b_ep, b_eo, b_el});
    end
    checks++;
    if (a_data !== 8'h00 || b_data !== 8'h00) begin
      errors++;
      $display("FAIL reset out_data: got a=%02h b=%02h, required 00", a_data, b_data);
    end
    checks++;
    if (a_fid !== 24'h0 || b_fid !== 24'h0) begin
      errors++;
      $display("FAIL reset frame_id: got a=%06h b=%06h, required 000000", a_fid, b_fid);
    end
    checks++;
    if (a_fc !== 16'h0 || b_fc !== 16'h0) begin
      errors++;
      $display("FAIL reset frame_cnt: got a=%0d b=%0d, required 0", a_fc, b_fc);
    end
    checks++;
    if (a_lvl !== 3'd0 || b_lvl !== 5'd0) begin
      errors++;
      $display("FAIL reset fifo_level: got a=%0d b=%0d, required 0", a_lvl, b_lvl);
    end
    reset = 1'b1;
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    repeat (2) tick();
  endtask

  task automatic test_nominal();
    stim.delete();
    add_header(24'hA50102);
    add_byte(8'h3C);
    add_byte(8'h7E);
    add_gap(2);
    play_stim();
    score_run("nominal", 1'b0);
  endtask

  task automatic test_partial();
    stim.delete();
    add_header(24'h123456);
    add_byte(8'h11);
    add_bits(8'h16, 5);
    add_gap(2);
    play_stim();
    score_run("partial", 1'b0);
  endtask

  task automatic test_short_then_nominal();
    stim.delete();
    add_header(24'hC0FFEE);
    stim = stim[0:19];
    add_gap(1);
    add_header(24'hA50102);
    add_byte(8'h3C);
    add_byte(8'h7E);
    add_gap(2);
    play_stim();
    score_run("short", 1'b0);
  endtask

  task automatic test_backpressure();
    stim.delete();
    add_header(24'h0BADF0);
    for (int i = 1; i <= 8; i++) add_byte(8'(i));
    add_gap(2);
    rdy = 1'b0;
    play_stim();
    repeat (4) tick();
    checks++;
    if (a_lvl !== 3'd4 || b_lvl !== 5'd4) begin
      errors++;
      $display("FAIL backpressure fifo_level: got a=%0d b=%0d, required 4", a_lvl, b_lvl);
    end
    checks++;
    if (a_data !== 8'h01 || a_last !== 1'b0 || !a_valid) begin
      errors++;
      $display("FAIL backpressure held_head: got data=%02h last=%0b valid=%0b, required 01/0/1", a_data, a_last, a_valid);
    end
    rdy = 1'b1;
    score_run("backpressure", 1'b1);
  endtask

  task automatic test_overlength();
    stim.delete();
    add_header(24'h00BEEF);
    for (int i = 0; i < 6; i++) add_byte(8'hA0 + 8'(i));
    add_gap(2);
    play_stim();
    score_run("overlength", 1'b0);
  endtask

  task automatic test_random();
    int nb, rem;
    for (int it = 0; it < 12; it++) begin
      stim.delete();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        nb = $urandom_range(0, 10);
        for (int k = 0; k < nb; k++) add_byte(8'($urandom));
        rem = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
        if (nb == 0 && rem == 0) rem = 3;
        add_bits(8'($urandom), rem);
        add_gap($urandom_range(1, 3));
      end
      add_gap(2);
      play_stim();
      score_run($sformatf("random%0d", it), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    stim.delete();
    add_header(24'h5A5A5A);
    add_byte(8'h55);
    add_bits(8'h05, 3);
    for (int i = 0; i < 13; i++) stim.push_back({1'b1, 1'($urandom)});
    add_gap(2);
    obs_a.delete();
    obs_b.delete();
    for (int i = 0; i < stim.size(); i++) begin
      ff_en = stim[i][1];
      ff_data = stim[i][0];
      reset = (i == 36) ? 1'b0 : 1'b1;
      tick();
      if (i == 36) begin
        for (int d = 0; d < 2; d++) begin
          s_short[d] = n_short[d]; s_part[d] = n_part[d]; s_over[d] = n_over[d];
          s_long[d] = n_long[d]; s_id[d] = n_id[d];
        end
      end
    end
    reset = 1'b1;
    ff_en = 1'b0;
    repeat (4) tick();
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    checks++;
    if (a_lvl !== 3'd0 || b_lvl !== 5'd0 || a_valid || b_valid) begin
      errors++;
      $display("FAIL reset_mid level: got a=%0d b=%0d, required 0", a_lvl, b_lvl);
    end
    checks++;
    if (obs_a.size() != 0 || obs_b.size() != 0) begin
      errors++;
      $display("FAIL reset_mid entries: got a=%0d b=%0d, required 0", obs_a.size(), obs_b.size());
    end
    checks++;
    if ((n_short[0] - s_short[0]) != 0 || (n_id[0] - s_id[0]) != 0 || a_fid !== 24'h0) begin
      errors++;
      $display("FAIL reset_mid ignore_tail: got short=%0d id=%0d frame_id=%06h, required 0/0/000000",
               n_short[0] - s_short[0], n_id[0] - s_id[0], a_fid);
    end
    checks++;
    if (a_fc !== 16'h0 || b_fc !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid frame_cnt: got a=%0d b=%0d, required 0", a_fc, b_fc);
    end
    stim.delete();
    add_header(24'hA50102);
    add_byte(8'h3C);
    add_byte(8'h7E);
    add_gap(2);
    play_stim();
    score_run("after_reset", 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_partial();
    test_short_then_nominal();
    test_backpressure();
    test_overlength();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
